// File: rtl/game_ctl.sv
// rtl/game_ctl.sv - two-player game sequencer: start hold, scoring, winner screen timing
module game_ctl #(
    parameter int WIN_SCORE         = 3,
    parameter int SCORE_W           = 4,
    parameter int START_HOLD_FRAMES = 30,
    parameter int END_FRAMES        = 180
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               p1_point,
    input  logic               p2_point,
    output logic [1:0]         game_state,
    output logic               game_en,
    output logic               round_start,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score
);

    // Encoding is shared with the draw modules; all four codes are real states.
    typedef enum logic [1:0] {
        START    = 2'b00,
        GAME     = 2'b01,
        PLAYER_2 = 2'b10,
        PLAYER_1 = 2'b11
    } state_t;

    localparam int MAX_FRAMES = (START_HOLD_FRAMES > END_FRAMES) ? START_HOLD_FRAMES : END_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(START_HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0]   END_LAST  = CNT_W'(END_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   end_cnt_q, end_cnt_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic               round_start_q, round_start_d;
    logic               game_en_q, game_en_d;
    logic [SCORE_W-1:0] p1_inc;
    logic [SCORE_W-1:0] p2_inc;

    // Next-state, counter and score logic; outputs derive from the next state so they register cleanly.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        end_cnt_d     = end_cnt_q;
        p1_score_d    = p1_score_q;
        p2_score_d    = p2_score_q;
        round_start_d = 1'b0;
        p1_inc        = p1_score_q + {{(SCORE_W-1){1'b0}}, p1_point};
        p2_inc        = p2_score_q + {{(SCORE_W-1){1'b0}}, p2_point};

        case (state_q)
            START: begin
                p1_score_d = '0;
                p2_score_d = '0;
                end_cnt_d  = '0;
                if (!start_btn) begin
                    hold_cnt_d = '0;
                end else if (frame_tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d       = GAME;
                        round_start_d = 1'b1;
                        hold_cnt_d    = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end
            end
            GAME: begin
                hold_cnt_d = '0;
                end_cnt_d  = '0;
                p1_score_d = p1_inc;
                p2_score_d = p2_inc;
                // Player 1 wins ties by fixed priority.
                if (p1_inc == WIN) begin
                    state_d = PLAYER_1;
                end else if (p2_inc == WIN) begin
                    state_d = PLAYER_2;
                end
            end
            PLAYER_1, PLAYER_2: begin
                // hold_cnt stays cleared so a held button must re-arm from zero in START.
                hold_cnt_d = '0;
                if (frame_tick) begin
                    if (end_cnt_q == END_LAST) begin
                        state_d    = START;
                        p1_score_d = '0;
                        p2_score_d = '0;
                        end_cnt_d  = '0;
                    end else begin
                        end_cnt_d = end_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = START;
            end
        endcase

        game_en_d = (state_d == GAME);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= START;
            hold_cnt_q    <= '0;
            end_cnt_q     <= '0;
            p1_score_q    <= '0;
            p2_score_q    <= '0;
            round_start_q <= 1'b0;
            game_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            end_cnt_q     <= end_cnt_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            round_start_q <= round_start_d;
            game_en_q     <= game_en_d;
        end
    end

    assign game_state  = state_q;
    assign game_en     = game_en_q;
    assign round_start = round_start_q;
    assign p1_score    = p1_score_q;
    assign p2_score    = p2_score_q;

endmodule

// File: tb/tb_game_ctl.sv
// tb/tb_game_ctl.sv - self-checking bench for game_ctl with directed scenarios and a random run
module tb_game_ctl;

    localparam int WIN  = 3;
    localparam int SW   = 4;
    localparam int HOLD = 4;
    localparam int ENDF = 5;

    localparam logic [1:0] S_START = 2'b00;
    localparam logic [1:0] S_GAME  = 2'b01;
    localparam logic [1:0] S_P2    = 2'b10;
    localparam logic [1:0] S_P1    = 2'b11;

    logic          clk;
    logic          rst;
    logic          frame_tick;
    logic          start_btn;
    logic          p1_point;
    logic          p2_point;
    logic [1:0]    game_state;
    logic          game_en;
    logic          round_start;
    logic [SW-1:0] p1_score;
    logic [SW-1:0] p2_score;

    int n_cmp;
    int n_bad;

    // Reference model: whole-game view in plain integers.
    logic [1:0] m_state;
    int         m_p1;
    int         m_p2;
    int         m_frames_held;
    int         m_frames_shown;
    logic       m_round;

    game_ctl #(
        .WIN_SCORE        (WIN),
        .SCORE_W          (SW),
        .START_HOLD_FRAMES(HOLD),
        .END_FRAMES       (ENDF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .game_state (game_state),
        .game_en    (game_en),
        .round_start(round_start),
        .p1_score   (p1_score),
        .p2_score   (p2_score)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic ft, input logic sb, input logic pp1, input logic pp2);
        m_round = 1'b0;
        if (r) begin
            m_state        = S_START;
            m_p1           = 0;
            m_p2           = 0;
            m_frames_held  = 0;
            m_frames_shown = 0;
        end else if (m_state == S_START) begin
            m_p1 = 0;
            m_p2 = 0;
            if (!sb) m_frames_held = 0;
            else if (ft) begin
                m_frames_held++;
                if (m_frames_held == HOLD) begin
                    m_state       = S_GAME;
                    m_round       = 1'b1;
                    m_frames_held = 0;
                end
            end
        end else if (m_state == S_GAME) begin
            m_p1 += int'(pp1);
            m_p2 += int'(pp2);
            if (m_p1 == WIN) m_state = S_P1;
            else if (m_p2 == WIN) m_state = S_P2;
        end else begin
            if (ft) begin
                m_frames_shown++;
                if (m_frames_shown == ENDF) begin
                    m_state        = S_START;
                    m_p1           = 0;
                    m_p2           = 0;
                    m_frames_shown = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic ft, input logic sb, input logic pp1, input logic pp2);
        rst        = r;
        frame_tick = ft;
        start_btn  = sb;
        p1_point   = pp1;
        p2_point   = pp2;
        @(posedge clk);
        model_step(r, ft, sb, pp1, pp2);
        @(negedge clk);
    endtask

    task automatic go_to_game();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < HOLD; i++) drive(0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (game_state !== S_START || game_en !== 1'b0 || round_start !== 1'b0 ||
            p1_score !== 4'd0 || p2_score !== 4'd0) begin
            n_bad++;
            $display("FAIL reset: state=%b en=%b rs=%b s=%0d/%0d, required 00 0 0 0/0",
                     game_state, game_en, round_start, p1_score, p2_score);
        end
    endtask

    task automatic test_start_hold();
        for (int i = 0; i < HOLD - 1; i++) begin
            drive(0, 1, 1, 0, 0);
            drive(0, 0, 1, 0, 0);
        end
        n_cmp++;
        if (game_state !== S_START) begin
            n_bad++;
            $display("FAIL hold_first_run: state=%b required %b", game_state, S_START);
        end
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < HOLD; i++) begin
            drive(0, 1, 1, 0, 0);
            if (i < HOLD - 1) begin
                n_cmp++;
                if (game_state !== S_START || round_start !== 1'b0) begin
                    n_bad++;
                    $display("FAIL hold_early_tick%0d: state=%b rs=%b required 00 0", i, game_state, round_start);
                end
                drive(0, 0, 1, 0, 0);
            end
        end
        n_cmp++;
        if (game_state !== S_GAME || round_start !== 1'b1 || game_en !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_enter_game: state=%b rs=%b en=%b required 01 1 1", game_state, round_start, game_en);
        end
        drive(0, 1, 1, 0, 0);
        n_cmp++;
        if (game_state !== S_GAME || round_start !== 1'b0) begin
            n_bad++;
            $display("FAIL round_start_one_cycle: state=%b rs=%b required 01 0", game_state, round_start);
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_p1_win();
        for (int k = 1; k <= WIN; k++) begin
            drive(0, 0, 0, 1, 0);
            n_cmp++;
            if (p1_score !== 4'(k) || p2_score !== 4'd0 ||
                game_state !== ((k == WIN) ? S_P1 : S_GAME) || game_en !== (k != WIN)) begin
                n_bad++;
                $display("FAIL p1_step%0d: s=%0d/%0d state=%b en=%b required %0d/0 state=%b en=%b",
                         k, p1_score, p2_score, game_state, game_en, k,
                         (k == WIN) ? S_P1 : S_GAME, (k != WIN));
            end
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_simultaneous();
        go_to_game();
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);
        n_cmp++;
        if (p1_score !== 4'd2 || p2_score !== 4'd2 || game_state !== S_GAME) begin
            n_bad++;
            $display("FAIL simul_2_2: s=%0d/%0d state=%b required 2/2 01", p1_score, p2_score, game_state);
        end
        drive(0, 0, 0, 1, 1);
        n_cmp++;
        if (p1_score !== 4'd3 || p2_score !== 4'd3 || game_state !== S_P1) begin
            n_bad++;
            $display("FAIL simul_tie: s=%0d/%0d state=%b required 3/3 11", p1_score, p2_score, game_state);
        end
        go_to_game();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        n_cmp++;
        if (p1_score !== 4'd2 || p2_score !== 4'd1 || game_state !== S_GAME) begin
            n_bad++;
            $display("FAIL simul_2_1: s=%0d/%0d state=%b required 2/1 01", p1_score, p2_score, game_state);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (game_state !== S_START || p1_score !== 4'd0 || p2_score !== 4'd0 ||
            game_en !== 1'b0 || round_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: state=%b s=%0d/%0d en=%b rs=%b required 00 0/0 0 0",
                     game_state, p1_score, p2_score, game_en, round_start);
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_points_ignored();
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        n_cmp++;
        if (p1_score !== 4'd0 || p2_score !== 4'd0 || game_state !== S_START) begin
            n_bad++;
            $display("FAIL ignore_in_start: s=%0d/%0d state=%b required 0/0 00", p1_score, p2_score, game_state);
        end
        go_to_game();
        for (int i = 0; i < WIN; i++) drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 1);
        n_cmp++;
        if (p1_score !== 4'd3 || p2_score !== 4'd0 || game_state !== S_P1 || game_en !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_in_p1: s=%0d/%0d state=%b en=%b required 3/0 11 0",
                     p1_score, p2_score, game_state, game_en);
        end
    endtask

    task automatic test_end_timeout();
        go_to_game();
        for (int i = 0; i < WIN; i++) drive(0, 0, 1, 0, 1);
        n_cmp++;
        if (game_state !== S_P2 || p2_score !== 4'd3) begin
            n_bad++;
            $display("FAIL p2_win: state=%b s2=%0d required 10 3", game_state, p2_score);
        end
        for (int i = 0; i < ENDF - 1; i++) begin
            drive(0, 1, 1, 0, 0);
            drive(0, 0, 1, 0, 0);
        end
        n_cmp++;
        if (game_state !== S_P2 || p1_score !== 4'd0 || p2_score !== 4'd3) begin
            n_bad++;
            $display("FAIL end_hold: state=%b s=%0d/%0d required 10 0/3", game_state, p1_score, p2_score);
        end
        drive(0, 1, 1, 0, 0);
        n_cmp++;
        if (game_state !== S_START || p1_score !== 4'd0 || p2_score !== 4'd0) begin
            n_bad++;
            $display("FAIL end_return: state=%b s=%0d/%0d required 00 0/0", game_state, p1_score, p2_score);
        end
        for (int i = 0; i < HOLD - 1; i++) drive(0, 1, 1, 0, 0);
        n_cmp++;
        if (game_state !== S_START) begin
            n_bad++;
            $display("FAIL rearm_early: state=%b required 00", game_state);
        end
        drive(0, 1, 1, 0, 0);
        n_cmp++;
        if (game_state !== S_GAME || round_start !== 1'b1) begin
            n_bad++;
            $display("FAIL rearm_game: state=%b rs=%b required 01 1", game_state, round_start);
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic sb_lvl;
        logic r, ft, pp1, pp2;
        int   shown;
        sb_lvl = 1'b0;
        shown  = 0;
        drive(1, 0, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) sb_lvl = ~sb_lvl;
            r   = ($urandom_range(0, 299) == 0);
            ft  = ($urandom_range(0, 2) == 0);
            pp1 = ($urandom_range(0, 4) == 0);
            pp2 = ($urandom_range(0, 4) == 0);
            drive(r, ft, sb_lvl, pp1, pp2);
            n_cmp++;
            if (game_state !== m_state || game_en !== (m_state == S_GAME) || round_start !== m_round ||
                p1_score !== 4'(m_p1) || p2_score !== 4'(m_p2)) begin
                n_bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cycle%0d: state=%b en=%b rs=%b s=%0d/%0d required %b %b %b %0d/%0d",
                             c, game_state, game_en, round_start, p1_score, p2_score,
                             m_state, (m_state == S_GAME), m_round, m_p1, m_p2);
                end
            end
        end
    endtask

    initial begin
        clk            = 1'b0;
        rst            = 1'b0;
        frame_tick     = 1'b0;
        start_btn      = 1'b0;
        p1_point       = 1'b0;
        p2_point       = 1'b0;
        n_cmp          = 0;
        n_bad          = 0;
        m_state        = S_START;
        m_p1           = 0;
        m_p2           = 0;
        m_frames_held  = 0;
        m_frames_shown = 0;
        m_round        = 1'b0;
        @(negedge clk);
        test_reset();
        test_start_hold();
        test_p1_win();
        test_simultaneous();
        test_reset_mid();
        test_points_ignored();
        test_end_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
